// File: rtl/dsp_mul_arbiter_if.sv
// dsp_mul_arbiter_if: request/response bundle for the two-requester shared multiplier.
interface dsp_mul_arbiter_if #(parameter int W = 16);
    logic           req0_valid, req0_ready;
    logic [W-1:0]   req0_a, req0_b;
    logic           req1_valid, req1_ready;
    logic [W-1:0]   req1_a, req1_b;
    logic           stall;
    logic           rsp0_valid, rsp1_valid;
    logic [2*W-1:0] rsp0_p, rsp1_p;
    logic           busy;
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, stall,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_p, rsp1_valid, rsp1_p, busy
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, stall,
        output req0_ready, req1_ready, rsp0_valid, rsp0_p, rsp1_valid, rsp1_p, busy
    );
endinterface

// File: rtl/dsp_mul_arbiter.sv
// dsp_mul_arbiter: round-robin sharing of one LAT-stage W x W multiplier between two requesters.
// Define DSP_ARB_SIGNED_EN for two's-complement operands and product (unsigned otherwise).
module dsp_mul_arbiter #(
    parameter int W   = 16,
    parameter int LAT = 2
) (
    input logic clk,
    input logic rst,
    dsp_mul_arbiter_if.slave bus
);
    logic           last, xfer, gid, fire0, fire1;
    logic [LAT-1:0] vld, id;
    logic [2*W-1:0] prod [LAT];
    logic [2*W-1:0] mul, hold0, hold1;
    logic [W-1:0]   a, b;

    // last=1 means requester 1 won most recently, so requester 0 wins the next contention
    assign bus.req0_ready = ~rst & ~bus.stall & bus.req0_valid & (~bus.req1_valid | last);
    assign bus.req1_ready = ~rst & ~bus.stall & bus.req1_valid & (~bus.req0_valid | ~last);
    assign xfer = bus.req0_ready | bus.req1_ready;
    assign gid  = bus.req1_ready;
    assign a    = gid ? bus.req1_a : bus.req0_a;
    assign b    = gid ? bus.req1_b : bus.req0_b;

`ifdef DSP_ARB_SIGNED_EN
    logic signed [2*W-1:0] sa, sb;
    assign sa  = {{W{a[W-1]}}, a};
    assign sb  = {{W{b[W-1]}}, b};
    assign mul = sa * sb;
`else
    assign mul = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif

    assign fire0 = vld[LAT-1] & ~id[LAT-1] & ~bus.stall;
    assign fire1 = vld[LAT-1] & id[LAT-1] & ~bus.stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld   <= '0;
            id    <= '0;
            last  <= 1'b1;
            hold0 <= '0;
            hold1 <= '0;
        end else if (!bus.stall) begin
            vld[0] <= xfer;
            id[0]  <= gid;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                id[i]  <= id[i-1];
            end
            if (xfer) last <= gid;
            if (fire0) hold0 <= prod[LAT-1];
            if (fire1) hold1 <= prod[LAT-1];
        end
    end

    // product datapath needs no reset: it is only observed through vld
    always_ff @(posedge clk) begin
        if (!bus.stall) begin
            prod[0] <= mul;
            for (int i = 1; i < LAT; i++) prod[i] <= prod[i-1];
        end
    end

    assign bus.rsp0_valid = fire0;
    assign bus.rsp1_valid = fire1;
    assign bus.rsp0_p     = fire0 ? prod[LAT-1] : hold0;
    assign bus.rsp1_p     = fire1 ? prod[LAT-1] : hold1;
    assign bus.busy       = |vld;
endmodule

// File: tb/tb_dsp_mul_arbiter.sv
// tb_dsp_mul_arbiter: directed and randomized checks of dsp_mul_arbiter against an op-queue model.
module tb_dsp_mul_arbiter;
    localparam int W = 16;
    localparam int LAT = 2;

    typedef struct {
        logic           id;
        logic [2*W-1:0] p;
        int             age;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dsp_mul_arbiter_if #(.W(W)) bus ();
    dsp_mul_arbiter #(.W(W), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    op_t            ops[$];
    logic           mlast;
    logic [2*W-1:0] mh0, mh1;
    int             checks = 0;
    int             errors = 0;
    logic           s_r0, s_r1, s_v0, s_v1, s_busy;
    logic [2*W-1:0] s_p0, s_p1;
    logic           e_r0, e_r1, e_v0, e_v1, e_busy;
    logic [2*W-1:0] e_p0, e_p1;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef DSP_ARB_SIGNED_EN
        return (2*W)'(longint'($signed(x)) * longint'($signed(y)));
`else
        return (2*W)'(longint'(x) * longint'(y));
`endif
    endfunction

    task automatic model_reset();
        ops.delete();
        mlast = 1'b1;
        mh0 = '0;
        mh1 = '0;
    endtask

    // One cycle: drive at negedge, sample after settling, advance the model at posedge.
    task automatic step(input logic v0, input logic v1, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input logic st);
        op_t nq[$];
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
        bus.stall = st;
        #1;
        s_r0 = bus.req0_ready; s_r1 = bus.req1_ready;
        s_v0 = bus.rsp0_valid; s_v1 = bus.rsp1_valid;
        s_p0 = bus.rsp0_p; s_p1 = bus.rsp1_p; s_busy = bus.busy;
        e_r0 = !st && v0 && (!v1 || mlast);
        e_r1 = !st && v1 && (!v0 || !mlast);
        e_v0 = 1'b0; e_v1 = 1'b0; e_p0 = mh0; e_p1 = mh1;
        e_busy = ops.size() > 0;
        foreach (ops[i]) begin
            if (ops[i].age == LAT && !st) begin
                if (ops[i].id) begin e_v1 = 1'b1; e_p1 = ops[i].p; end
                else begin e_v0 = 1'b1; e_p0 = ops[i].p; end
            end
        end
        @(posedge clk);
        if (!st) begin
            foreach (ops[i]) if (ops[i].age < LAT) nq.push_back('{ops[i].id, ops[i].p, ops[i].age + 1});
            if (e_r0) nq.push_back('{1'b0, ref_mul(a0, b0), 1});
            if (e_r1) nq.push_back('{1'b1, ref_mul(a1, b1), 1});
            ops = nq;
            if (e_r0 || e_r1) mlast = e_r1;
            mh0 = e_p0;
            mh1 = e_p1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.stall = 1'b0;
        bus.req0_a = 16'd1; bus.req0_b = 16'd1; bus.req1_a = 16'd1; bus.req1_b = 16'd1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got r=%b%b v=%b%b busy=%b expected all 0",
                     bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy);
        end
        checks++;
        if (bus.rsp0_p !== '0 || bus.rsp1_p !== '0) begin
            errors++;
            $display("FAIL reset_p: got p0=%h p1=%h expected 0", bus.rsp0_p, bus.rsp1_p);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        step(1'b1, 1'b0, 16'd3, 16'd5, '0, '0, 1'b0);
        checks++;
        if ({s_r0, s_r1, s_busy} !== 3'b100) begin
            errors++;
            $display("FAIL single_grant: got r=%b%b busy=%b expected r=10 busy=0", s_r0, s_r1, s_busy);
        end
        idle();
        checks++;
        if ({s_v0, s_v1, s_busy} !== 3'b001) begin
            errors++;
            $display("FAIL single_mid: got v=%b%b busy=%b expected v=00 busy=1", s_v0, s_v1, s_busy);
        end
        idle();
        checks++;
        if ({s_v0, s_v1, s_busy} !== 3'b101 || s_p0 !== 32'h0000000F) begin
            errors++;
            $display("FAIL single_rsp: got v=%b%b busy=%b p0=%h expected v=10 busy=1 p0=0000000f",
                     s_v0, s_v1, s_busy, s_p0);
        end
        idle();
        checks++;
        if ({s_v0, s_busy} !== 2'b00 || s_p0 !== 32'h0000000F) begin
            errors++;
            $display("FAIL single_hold: got v0=%b busy=%b p0=%h expected v0=0 busy=0 p0=0000000f",
                     s_v0, s_busy, s_p0);
        end
    endtask

    task automatic test_contention();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 16'd2, 16'd7, 16'd4, 16'd4, 1'b0);
        checks++;
        if ({s_r0, s_r1} !== 2'b10) begin
            errors++;
            $display("FAIL contend_first: got r=%b%b expected 10", s_r0, s_r1);
        end
        step(1'b0, 1'b1, '0, '0, 16'd4, 16'd4, 1'b0);
        checks++;
        if ({s_r0, s_r1} !== 2'b01) begin
            errors++;
            $display("FAIL contend_second: got r=%b%b expected 01", s_r0, s_r1);
        end
        idle();
        checks++;
        if ({s_v0, s_v1} !== 2'b10 || s_p0 !== 32'd14) begin
            errors++;
            $display("FAIL contend_rsp0: got v=%b%b p0=%0d expected v=10 p0=14", s_v0, s_v1, s_p0);
        end
        idle();
        checks++;
        if ({s_v0, s_v1} !== 2'b01 || s_p1 !== 32'd16) begin
            errors++;
            $display("FAIL contend_rsp1: got v=%b%b p1=%0d expected v=01 p1=16", s_v0, s_v1, s_p1);
        end
    endtask

    task automatic test_alternate();
        int n0 = 0;
        int n1 = 0;
        for (int i = 0; i < 20 + LAT + 1; i++) begin
            if (i < 20) step(1'b1, 1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
            else idle();
            if (i < 20) begin
                checks++;
                if (s_r0 !== (i % 2 == 0) || s_r1 !== (i % 2 == 1)) begin
                    errors++;
                    $display("FAIL alternate_grant %0d: got r=%b%b expected r0=%0d", i, s_r0, s_r1, i % 2 == 0);
                end
            end
            if (s_v0 && s_p0 === e_p0) n0++;
            if (s_v1 && s_p1 === e_p1) n1++;
        end
        checks++;
        if (n0 != 10 || n1 != 10) begin
            errors++;
            $display("FAIL alternate_count: got %0d/%0d good responses expected 10/10", n0, n1);
        end
    endtask

    task automatic test_stall();
        int t0 = -1;
        int t1 = -1;
        logic [2*W-1:0] q0 = '0;
        logic [2*W-1:0] q1 = '0;
        for (int i = 0; i < 9; i++) begin
            logic st;
            st = (i >= 2 && i <= 4);
            step((i == 0) || st, (i == 1) || st, 16'd9, 16'd11, 16'd12, 16'd13, st);
            if (st) begin
                checks++;
                if ({s_r0, s_r1, s_v0, s_v1} !== 4'b0) begin
                    errors++;
                    $display("FAIL stall_block %0d: got r=%b%b v=%b%b expected 0000", i, s_r0, s_r1, s_v0, s_v1);
                end
            end
            if (s_v0 && t0 < 0) begin t0 = i; q0 = s_p0; end
            if (s_v1 && t1 < 0) begin t1 = i; q1 = s_p1; end
        end
        checks++;
        if (t0 != LAT + 3 || t1 != LAT + 4) begin
            errors++;
            $display("FAIL stall_latency: got rsp cycles %0d/%0d expected %0d/%0d", t0, t1, LAT + 3, LAT + 4);
        end
        checks++;
        if (q0 !== 32'd99 || q1 !== 32'd156) begin
            errors++;
            $display("FAIL stall_products: got %0d/%0d expected 99/156", q0, q1);
        end
    endtask

    task automatic test_sign();
        logic [2*W-1:0] want;
`ifdef DSP_ARB_SIGNED_EN
        want = 32'hFFFFFFF1;
`else
        want = 32'h0004FFF1;
`endif
        step(1'b1, 1'b0, 16'hFFFD, 16'h0005, '0, '0, 1'b0);
        idle();
        idle();
        checks++;
        if (s_v0 !== 1'b1 || s_p0 !== want) begin
            errors++;
            $display("FAIL sign: got v0=%b p0=%h expected v0=1 p0=%h", s_v0, s_p0, want);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300 + LAT + 4; i++) begin
            if (i < 300)
                step(1'($urandom), 1'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                     $urandom_range(0, 6) == 0);
            else idle();
            checks++;
            if ({s_r0, s_r1, s_v0, s_v1, s_busy} !== {e_r0, e_r1, e_v0, e_v1, e_busy} ||
                s_p0 !== e_p0 || s_p1 !== e_p1) begin
                errors++;
                $display("FAIL random %0d: got r=%b%b v=%b%b busy=%b p0=%h p1=%h expected r=%b%b v=%b%b busy=%b p0=%h p1=%h",
                         i, s_r0, s_r1, s_v0, s_v1, s_busy, s_p0, s_p1,
                         e_r0, e_r1, e_v0, e_v1, e_busy, e_p0, e_p1);
            end
        end
    endtask

    task automatic test_reset_inflight();
        step(1'b1, 1'b0, 16'd21, 16'd3, '0, '0, 1'b0);
        step(1'b0, 1'b1, '0, '0, 16'd6, 16'd7, 1'b0);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy} !== 5'b0 ||
            bus.rsp0_p !== '0 || bus.rsp1_p !== '0) begin
            errors++;
            $display("FAIL reset_inflight: got r=%b%b v=%b%b busy=%b p0=%h p1=%h expected all 0",
                     bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy,
                     bus.rsp0_p, bus.rsp1_p);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < LAT + 2; i++) begin
            idle();
            checks++;
            if ({s_v0, s_v1, s_busy} !== 3'b0) begin
                errors++;
                $display("FAIL reset_discard %0d: got v=%b%b busy=%b expected 000", i, s_v0, s_v1, s_busy);
            end
        end
        step(1'b1, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        checks++;
        if ({s_r0, s_r1} !== 2'b10) begin
            errors++;
            $display("FAIL reset_last: got r=%b%b expected 10", s_r0, s_r1);
        end
        repeat (LAT + 1) idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_alternate();
        test_stall();
        test_sign();
        test_random();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dsp_mul_arbiter.md
# dsp_mul_arbiter

Shares one pipelined W×W multiplier, which maps onto an iCE40UP5K SB_MAC16 DSP tile, between two independent requesters. Arbitration is round-robin with a valid/ready handshake, and each result is steered back to its requester after a fixed latency. Use it where several calculation units, such as the self-checking DSP calculators that drive the board LEDs, must not each consume their own DSP tile.

## Interface
Parameters:
- `W`, default 16: operand width. Product width is 2W.
- `LAT`, default 2: multiplier pipeline depth in cycles. Legal range 1..4.

Ports:
- `clk` input, 1: system clock.
- `rst` input, 1: reset, asynchronous, active-high.
- `req0_valid` input, 1: requester 0 has an operand pair.
- `req0_ready` output, 1: requester 0 is granted this cycle.
- `req0_a`, `req0_b` input, W: requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `stall` input, 1: freezes the pipeline and blocks new grants.
- `rsp0_valid` output, 1: requester 0 result is valid. One-cycle pulse, no backpressure.
- `rsp0_p` output, 2W: requester 0 product.
- `rsp1_valid`, `rsp1_p`: same as requester 0, for requester 1.
- `busy` output, 1: at least one operation is in flight.

## Operation
Transfer rule:
- A transfer occurs when `reqN_valid & reqN_ready` in a cycle.
- `reqN_ready` is combinational from the valids, `stall` and the last-grant pointer.
- `reqN_ready` never depends on `reqN_valid` of the other port being low.

Grant rule:
- At most one ready is high per cycle.
- Both ready are low while `stall`=1.
- Only one valid high: that requester is granted.
- Both valid high: the requester not granted most recently wins.

Last-grant pointer `last`:
- Updates only on a transfer.
- Reset value 1, so requester 0 wins the first contention.

Pipeline:
- LAT stages. Each stage holds {vld, id, operands or partial product}.
- A transfer loads stage 0 with vld=1, id=N.
- Without a transfer, stage 0 loads vld=0.
- All stages advance each cycle unless `stall`=1. While stalled, every stage holds, including vld and id.

Outputs:
- The final stage drives `rspN_valid` = vld & (id==N) & ~stall.
- `rspN_p` is driven by a register written when that response fires.
- `rspN_p` holds its value between responses.

Arithmetic:
- Unsigned W×W→2W by default. See Configuration for signed mode.
- No overflow is possible.

`busy`:
- OR of all stage vld bits.

Reset, asserted at any time:
- Clears all vld bits and sets `last`=1.
- Drives `rsp0_p`/`rsp1_p` to 0 and `rsp0_valid`/`rsp1_valid`/`busy` to 0.
- `req0_ready`/`req1_ready` are 0 while `rst`=1.
- In-flight operations are discarded and never produce a response.

## Timing
- Latency: an operand pair transferred in cycle k produces its response pulse in cycle k+LAT, when no stall intervenes.
- Each stalled cycle adds one cycle to the latency of every in-flight operation.
- Throughput: one operation per cycle in total. Under continuous contention each requester gets every other cycle.
- Back-to-back responses to the same requester are legal on consecutive cycles.
- A stall asserted in the cycle a result reaches the final stage suppresses the pulse. The pulse fires in the first cycle after `stall` drops.
- Simultaneous `rst` and transfer: reset wins and nothing is accepted.
- First grant is possible in the first cycle after `rst` deasserts.

## Configuration
- Macro `DSP_ARB_SIGNED_EN`.
- When defined, operands and product are two's-complement and the product is sign-correct in 2W bits.
- When undefined, operands and product are unsigned.
- Handshake, latency and arbitration are identical in both builds.

## Test plan
- Single op, W=16, LAT=2: transfer req0 a=3, b=5 in cycle 10 → `rsp0_valid` pulse in cycle 12 with `rsp0_p`=0x0000000F. `rsp1_valid` stays 0. `busy` is high in cycles 11–12.
- Contention right after reset: req0 and req1 both valid with (2,7) and (4,4) → req0 is granted first and req1 the next cycle. Responses are `rsp0_p`=14, then `rsp1_p`=16 on consecutive cycles.
- Continuous contention for 20 cycles → grants strictly alternate (0,1,0,1…). Each requester gets 10 responses, each matching its operands.
- Stall: assert `stall` for 3 cycles while 2 operations are in flight → both readies are 0 during the stall. Response latency grows by exactly 3 cycles and products are correct.
- Reset with 2 operations in flight → no response pulses. `busy`=0, `rsp0_p`=`rsp1_p`=0 and `last`=1, confirmed by req0 winning the next contention.
- Sign mode, req0 a=0xFFFD, b=0x0005 → 0xFFFFFFF1 with `DSP_ARB_SIGNED_EN` defined, 0x0004FFF1 without it.
